pulse_train_gen: RTL and testbench

- Multi-channel programmable pulse generator.
- Each channel runs a free-running or one-shot counter and drives a registered pulse output of programmable period and high-width.
- Generalises the fixed divide-by-3 single-cycle pulse source: after reset it reproduces that waveform on every enabled channel.
- Sits beside the clock generator and feeds strobes and enables to downstream timing logic.

---
 rtl/pulse_train_pkg.sv | 37 +++
 rtl/pulse_train_chan.sv | 132 +++++++++++++
 rtl/pulse_train_gen.sv | 49 ++++
 tb/tb_pulse_train_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types, reset defaults and helpers for the pulse_train_gen block.
// Optional feature macro: PULSE_TRAIN_PHASE_EN (per-channel start phase).
package pulse_train_pkg;

  // Width of the period/width/phase fields and of each channel counter.
  localparam int unsigned CFG_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CFG_W-1:0] DEF_PERIOD = CFG_W'(2);
  localparam logic [CFG_W-1:0] DEF_WIDTH  = CFG_W'(1);
  localparam logic [CFG_W-1:0] DEF_PHASE  = CFG_W'(0);

  typedef struct packed {
    logic [CFG_W-1:0] period;   // period is period+1 cycles
    logic [CFG_W-1:0] width;    // high cycles per period
    logic             oneshot;  // 1 = single period per trigger
    logic [CFG_W-1:0] phase;    // counter start value on RUN entry
  } cfg_t;

  // Power-up configuration: divide-by-3, single-cycle pulse.
  localparam cfg_t DEF_CFG = '{
    period:  DEF_PERIOD,
    width:   DEF_WIDTH,
    oneshot: 1'b0,
    phase:   DEF_PHASE
  };

  // Counter value loaded on RUN entry: the phase clamped to the period.
  function automatic logic [CFG_W-1:0] start_count(cfg_t c);
    return (c.phase > c.period) ? c.period : c.phase;
  endfunction

endpackage

// File: rtl/pulse_train_chan.sv
// One pulse channel: IDLE/RUN state, period counter, shadow and active
// configuration. New configuration written while running is held in the
// shadow copy and takes over at the next rollover, so a period in flight
// always completes with the values it started with.
// Optional feature macro: PULSE_TRAIN_PHASE_EN (start counter at phase).
module pulse_train_chan
  import pulse_train_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             trigger_i,
  input  logic             load_i,
  input  logic [CFG_W-1:0] period_i,
  input  logic [CFG_W-1:0] width_i,
  input  logic             oneshot_i,
  input  logic [CFG_W-1:0] phase_i,
  output logic             signal_o,
  output logic             busy_o,
  output logic             wrap_o
);

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  cfg_t             shadow_q, shadow_d;
  cfg_t             active_q, active_d;
  cfg_t             load_cfg;
  logic             rollover;

`ifndef PULSE_TRAIN_PHASE_EN
  // Phase has no effect in this build; the input is only sunk.
  logic unused_phase;
  assign unused_phase = ^phase_i;
`endif

  // Assemble the configuration presented on the write port.
  always_comb begin
    load_cfg.period  = period_i;
    load_cfg.width   = width_i;
    load_cfg.oneshot = oneshot_i;
`ifdef PULSE_TRAIN_PHASE_EN
    load_cfg.phase   = phase_i;
`else
    load_cfg.phase   = DEF_PHASE;
`endif
  end

  // Next state, counter, config hand-over and registered outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    signal_d = 1'b0;
    busy_d   = 1'b0;
    wrap_d   = 1'b0;
    active_d = active_q;
    shadow_d = load_i ? load_cfg : shadow_q;
    rollover = (cnt_q == active_q.period);

    if (!enable_i) begin
      // Disable overrides everything, including a trigger on the same edge.
      state_d  = IDLE;
      cnt_d    = '0;
      active_d = shadow_d;
    end else begin
      case (state_q)
        IDLE: begin
          // An idle channel adopts the latest config, including one written now.
          active_d = shadow_d;
          if (!shadow_d.oneshot || trigger_i) begin
            state_d  = RUN;
            cnt_d    = start_count(shadow_d);
            busy_d   = 1'b1;
            signal_d = (cnt_d < shadow_d.width);
          end
        end
        RUN: begin
          if (rollover) begin
            active_d = shadow_d;
            cnt_d    = '0;
            if (active_q.oneshot) begin
              // One-shot ends silently after its single period.
              state_d = IDLE;
            end else begin
              busy_d   = 1'b1;
              wrap_d   = 1'b1;
              signal_d = (cnt_d < shadow_d.width);
            end
          end else begin
            cnt_d    = cnt_q + 1'b1;
            busy_d   = 1'b1;
            signal_d = (cnt_d < active_q.width);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, outputs and configuration registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      shadow_q <= DEF_CFG;
      active_q <= DEF_CFG;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign signal_o = signal_q;
  assign busy_o   = busy_q;
  assign wrap_o   = wrap_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse generator. Decodes the configuration
// write port into per-channel strobes and gathers the channel outputs.
// CNT_W is expected to equal pulse_train_pkg::CFG_W, which sizes the
// per-channel config struct.
// Optional feature macro: PULSE_TRAIN_PHASE_EN (per-channel start phase).
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned CNT_W    = CFG_W,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] trigger,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [CNT_W-1:0]    load_period,
  input  logic [CNT_W-1:0]    load_width,
  input  logic                load_oneshot,
  input  logic [CNT_W-1:0]    load_phase,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] wrap
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // Writes addressed beyond the last channel match no channel.
    logic load_hit;
    assign load_hit = load && (load_ch == CH_W'(i));

    pulse_train_chan u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable_i  (enable[i]),
      .trigger_i (trigger[i]),
      .load_i    (load_hit),
      .period_i  (load_period),
      .width_i   (load_width),
      .oneshot_i (load_oneshot),
      .phase_i   (load_phase),
      .signal_o  (signal[i]),
      .busy_o    (busy[i]),
      .wrap_o    (wrap[i])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: constant vector table, hand-written
// multi-cycle sequences and randomized traffic against a waveform-list model.
module tb_pulse_train_gen;

  localparam int NCH = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] enable = '0;
  logic [NCH-1:0] trigger = '0;
  logic           load = 1'b0;
  logic [1:0]     load_ch = '0;
  logic [7:0]     load_period = '0;
  logic [7:0]     load_width = '0;
  logic           load_oneshot = 1'b0;
  logic [7:0]     load_phase = '0;
  logic [NCH-1:0] signal, busy, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_train_gen #(.CHANNELS(NCH), .CNT_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .trigger      (trigger),
    .load         (load),
    .load_ch      (load_ch),
    .load_period  (load_period),
    .load_width   (load_width),
    .load_oneshot (load_oneshot),
    .load_phase   (load_phase),
    .signal       (signal),
    .busy         (busy),
    .wrap         (wrap)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Each running channel holds the list of (signal, wrap) values still to
  // come in its current period; an empty list means the period is over.
  typedef struct { int p; int w; bit os; int ph; } mcfg_t;
  localparam mcfg_t M_DEF = '{p: 2, w: 1, os: 1'b0, ph: 0};

  mcfg_t    m_sh  [NCH];
  mcfg_t    m_act [NCH];
  bit       m_run [NCH];
  bit [1:0] m_q   [NCH][$];
  bit [NCH-1:0] m_sig = '0, m_busy = '0, m_wrap = '0;
  bit [1:0] m_e;

  task automatic m_fill(input int i, input int start, input bit first);
    for (int k = start; k <= m_act[i].p; k++)
      m_q[i].push_back({bit'(k < m_act[i].w), bit'(k == 0 && !first)});
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_sh[i] = M_DEF; m_act[i] = M_DEF; m_run[i] = 1'b0; m_q[i].delete();
      end
      m_sig = '0; m_busy = '0; m_wrap = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        m_e = 2'b00;
        if (load && int'(load_ch) == i) begin
          m_sh[i].p  = int'(load_period);
          m_sh[i].w  = int'(load_width);
          m_sh[i].os = load_oneshot;
`ifdef PULSE_TRAIN_PHASE_EN
          m_sh[i].ph = int'(load_phase);
`else
          m_sh[i].ph = 0;
`endif
        end
        if (!enable[i]) begin
          m_run[i] = 1'b0; m_q[i].delete(); m_act[i] = m_sh[i];
        end else if (!m_run[i]) begin
          m_act[i] = m_sh[i];
          if (!m_act[i].os || trigger[i]) begin
            m_run[i] = 1'b1;
            m_fill(i, (m_act[i].ph < m_act[i].p) ? m_act[i].ph : m_act[i].p, 1'b1);
          end
        end else if (m_q[i].size() == 0) begin
          if (m_act[i].os) m_run[i] = 1'b0;
          m_act[i] = m_sh[i];
          if (m_run[i]) m_fill(i, 0, 1'b0);
        end
        if (m_run[i]) m_e = m_q[i].pop_front();
        m_sig[i]  = m_e[1];
        m_wrap[i] = m_e[0];
        m_busy[i] = m_run[i];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then compare all outputs against the model.
  task automatic tick();
    @(posedge clock);
    #1;
    check("model_signal", 32'(signal), 32'(m_sig));
    check("model_busy",   32'(busy),   32'(m_busy));
    check("model_wrap",   32'(wrap),   32'(m_wrap));
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] trg, input logic ld,
                       input logic [1:0] ch, input logic [7:0] p, input logic [7:0] w,
                       input logic os, input logic [7:0] ph);
    enable = en; trigger = trg; load = ld; load_ch = ch;
    load_period = p; load_width = w; load_oneshot = os; load_phase = ph;
  endtask

  task automatic expect_out(input string name, input logic [3:0] s, input logic [3:0] b,
                            input logic [3:0] wr);
    check({name, "_signal"}, 32'(signal), 32'(s));
    check({name, "_busy"},   32'(busy),   32'(b));
    check({name, "_wrap"},   32'(wrap),   32'(wr));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] en, trg;
    logic       ld;
    logic [1:0] ch;
    logic [7:0] p, w;
    logic       os;
    logic [3:0] es, eb, ew;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] en, input logic [3:0] trg, input logic ld,
                     input logic [1:0] ch, input logic [7:0] p, input logic [7:0] w,
                     input logic os, input logic [3:0] es, input logic [3:0] eb,
                     input logic [3:0] ew);
    vec_t v;
    v.en = en; v.trg = trg; v.ld = ld; v.ch = ch; v.p = p; v.w = w; v.os = os;
    v.es = es; v.eb = eb; v.ew = ew;
    vecs.push_back(v);
  endtask

  int d_sig  [7] = '{1, 1, 1, 0, 0, 0, 1};
  int d_wrap [7] = '{1, 0, 0, 0, 0, 0, 1};

  initial begin
    // Default divide-by-3 on ch0 for 12 cycles.
    for (int k = 0; k < 12; k++)
      add(4'b0001, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0,
          (k % 3 == 0) ? 4'b0001 : 4'b0000, 4'b0001,
          (k % 3 == 0 && k > 0) ? 4'b0001 : 4'b0000);
    add(4'b0000, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0, 4'b0, 4'b0);
    // ch1: P=4, W=2 periodic -> 11000 repeating.
    add(4'b0000, 4'b0, 1'b1, 2'd1, 8'd4, 8'd2, 1'b0, 4'b0, 4'b0, 4'b0);
    for (int k = 0; k < 10; k++)
      add(4'b0010, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0,
          (k % 5 < 2) ? 4'b0010 : 4'b0000, 4'b0010,
          (k % 5 == 0 && k > 0) ? 4'b0010 : 4'b0000);
    add(4'b0000, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0, 4'b0, 4'b0);
    // ch2: one-shot P=3, W=1; waits for trigger, second trigger ignored.
    add(4'b0000, 4'b0,    1'b1, 2'd2, 8'd3, 8'd1, 1'b1, 4'b0,    4'b0,    4'b0);
    add(4'b0100, 4'b0,    1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0,    4'b0);
    add(4'b0100, 4'b0100, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0100, 4'b0100, 4'b0);
    add(4'b0100, 4'b0100, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0100, 4'b0);
    add(4'b0100, 4'b0,    1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0100, 4'b0);
    add(4'b0100, 4'b0,    1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0100, 4'b0);
    add(4'b0100, 4'b0,    1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0,    4'b0);
    add(4'b0100, 4'b0,    1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0,    4'b0);
    add(4'b0000, 4'b0,    1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'b0,    4'b0,    4'b0);

    // Reset state.
    repeat (3) tick();
    expect_out("reset", 4'b0, 4'b0, 4'b0);
    reset_n = 1'b1;

    foreach (vecs[n]) begin
      drive(vecs[n].en, vecs[n].trg, vecs[n].ld, vecs[n].ch, vecs[n].p, vecs[n].w,
            vecs[n].os, 8'd0);
      tick();
      expect_out($sformatf("vec%0d", n), vecs[n].es, vecs[n].eb, vecs[n].ew);
    end

    // ch0 reloaded with P=5, W=3 while at cnt=1: old period completes first.
    drive(4'b0001, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    tick(); expect_out("reload_e0", 4'b0001, 4'b0001, 4'b0);
    tick(); expect_out("reload_e1", 4'b0000, 4'b0001, 4'b0);
    drive(4'b0001, 4'b0, 1'b1, 2'd0, 8'd5, 8'd3, 1'b0, 8'd0);
    tick(); expect_out("reload_e2", 4'b0000, 4'b0001, 4'b0);
    drive(4'b0001, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      expect_out($sformatf("reload_e%0d", k + 3), 4'(d_sig[k]), 4'b0001, 4'(d_wrap[k]));
    end
    drive(4'b0000, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    tick();

    // Disable at cnt=1 clears everything on the next edge.
    drive(4'b0001, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    tick(); tick();
    expect_out("dis_cnt1", 4'b0001, 4'b0001, 4'b0);
    drive(4'b0000, 4'b0001, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    tick(); expect_out("dis_after", 4'b0, 4'b0, 4'b0);

    // Asynchronous reset mid-period, then default config again.
    drive(4'b0011, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1 expect_out("async_rst", 4'b0, 4'b0, 4'b0);
    tick(); expect_out("rst_held", 4'b0, 4'b0, 4'b0);
    reset_n = 1'b1;
    tick(); expect_out("post_rst_e0", 4'b0011, 4'b0011, 4'b0);
    tick(); expect_out("post_rst_e1", 4'b0000, 4'b0011, 4'b0);
    tick(); expect_out("post_rst_e2", 4'b0000, 4'b0011, 4'b0);
    tick(); expect_out("post_rst_e3", 4'b0011, 4'b0011, 4'b0011);

`ifdef PULSE_TRAIN_PHASE_EN
    // Phases 0, 1 and 9 (clamped to 2) on P=2, W=1.
    drive(4'b0000, 4'b0, 1'b1, 2'd0, 8'd2, 8'd1, 1'b0, 8'd0); tick();
    drive(4'b0000, 4'b0, 1'b1, 2'd1, 8'd2, 8'd1, 1'b0, 8'd1); tick();
    drive(4'b0000, 4'b0, 1'b1, 2'd2, 8'd2, 8'd1, 1'b0, 8'd9); tick();
    drive(4'b0111, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    tick(); expect_out("phase_e0", 4'b0001, 4'b0111, 4'b0000);
    tick(); expect_out("phase_e1", 4'b0100, 4'b0111, 4'b0100);
    tick(); expect_out("phase_e2", 4'b0010, 4'b0111, 4'b0010);
    tick(); expect_out("phase_e3", 4'b0001, 4'b0111, 4'b0001);
`endif

    // Randomized traffic checked against the model every edge.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(4'b1111, 4'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 15) == 0) enable[i] = ~enable[i];
        trigger[i] = ($urandom_range(0, 5) == 0);
      end
      load         = ($urandom_range(0, 3) == 0);
      load_ch      = 2'($urandom_range(0, 3));
      load_period  = 8'($urandom_range(0, 5));
      load_width   = 8'($urandom_range(0, 7));
      load_oneshot = ($urandom_range(0, 2) == 0);
      load_phase   = 8'($urandom_range(0, 9));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
